counter_mod: RTL
================

# counter_mod

Parametrised modulo-N up/down counter with synchronous load, clear and terminal-count cascade output. It is the next-generation general counter in the design: configurable width and modulus, selectable count direction, and an optional saturating mode. It is used standalone for event counting and chained through `tc` to build wider or multi-digit counters.

## Interface

- `WIDTH`, 8, count register width in bits.
- `MODULUS`, 256, count range is 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; out-of-range values are a configuration error flagged at elaboration.

- `clk`  in  1  single clock. All state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `en`  in  1  count enable. One step per cycle while high.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  WIDTH  value to load.
- `clr`  in  1  synchronous clear to 0.
- `sat`  in  1  1 = saturate at the range end, 0 = wrap. Honoured only with `COUNTER_MOD_SAT_EN`.
- `count`  out  WIDTH  current count, registered.
- `tc`  out  1  combinational terminal count: `en & (up ? count==MODULUS-1 : count==0)`.
- `wrap`  out  1  registered one-cycle pulse, high the cycle after a wrap occurred.

## Operation

- Per-edge priority: `rst_n` low > `clr` > `load` > `en` > hold.
- Reset (`rst_n`=0 at the edge): `count`=0, `wrap`=0. `tc` follows its equation, so it reads `en & ~up` immediately after reset.
- `clr`: `count`=0, `wrap`=0. Ignores `en`, `load` and `up`.
- `load`: `count`=`load_val` if `load_val` <= MODULUS-1, otherwise `count`=MODULUS-1 (clamp). Sets `wrap`=0.
- `en`, up: if `count` < MODULUS-1, then `count`+1. If `count`==MODULUS-1, then wrap to 0 and set `wrap`=1, or hold in saturate mode with `wrap`=0.
- `en`, down: if `count` > 0, then `count`-1. If `count`==0, then wrap to MODULUS-1 and set `wrap`=1, or hold in saturate mode with `wrap`=0.
- Arithmetic is done at WIDTH+1 bits internally. `count` never leaves 0..MODULUS-1.
- `wrap` is 0 on every cycle except the one immediately following a wrap step.
- Cascade: drive the next stage's `en` from this stage's `tc`. Both stages then roll over on the same edge.
- Changing `up` or `sat` takes effect on the next edge. No state is kept about the previous direction.

## Timing

- Latency from input to `count`: 1 cycle for clear, load and step.
- `wrap`: asserted 1 cycle after the edge that performed the wrap. Width is exactly 1 cycle, unless wraps happen back to back. With MODULUS=2, free-running `en` gives a wrap every other cycle.
- `tc`: combinational, 0 cycles, with no registered delay. It depends on `en`, `up` and `count`.
- Reset mid-count: `count` is 0 on the edge where `rst_n` is sampled low. Any pending `wrap` is cleared on that same edge.
- `load` and `en` high together: load wins and no step occurs that cycle.

## Configuration

- `COUNTER_MOD_SAT_EN` defined: the `sat` input selects between saturate and wrap mode per cycle.
- `COUNTER_MOD_SAT_EN` undefined: `sat` is ignored and may be left unconnected. The counter always wraps, and no saturate logic is synthesised.

## Test plan

- Reset, then `en`=1 and `up`=1, with WIDTH=4 and MODULUS=10. Expect `count` to run 0,1..9,0. `tc`=1 while `count`=9. `wrap`=1 only in the cycle `count` first reads 0 after 9.
- WIDTH=4, MODULUS=10, `up`=0 from reset. Expect `count` to run 0,9,8. `tc`=1 in the first cycle. `wrap`=1 in the cycle `count`=9.
- Saturate mode: with `COUNTER_MOD_SAT_EN` defined and `sat`=1, up-count to 9 then hold `en`. Expect `count` to stay at 9 and `wrap` to stay 0. Without the macro, the same stimulus wraps to 0.
- Load clamp and priority: set `load`=1 with `load_val`=13 and MODULUS=10. Expect `count`=9. Then assert `clr` and `load` together. Expect `count`=0.
- Mid-count reset: at `count`=7 with `en`=1, pull `rst_n` low for 1 cycle. Expect `count`=0 and `wrap`=0. Counting resumes 1, 2, ...
- Cascade: chain two MODULUS=10 instances, with the upper stage's `en` driven by the lower stage's `tc`. After 100 enabled cycles from reset, expect both stages to read 0. Expect the upper stage to read 1 after exactly 10 cycles.

Source files
------------

// File: rtl/counter_mod.sv
// Modulo-N up/down counter with synchronous clear/load, terminal-count cascade output and wrap pulse.
// Optional saturate mode is compiled in only when COUNTER_MOD_SAT_EN is defined.
module counter_mod #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  if ((MODULUS < 2) || (64'(MODULUS) > (64'(1) << WIDTH))) begin : g_bad_modulus
    $error("counter_mod: MODULUS %0d out of range for WIDTH %0d", MODULUS, WIDTH);
  end

  localparam int             LAST_INT = MODULUS - 1;
  localparam logic [WIDTH:0] LAST     = LAST_INT[WIDTH:0];

  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   load_ext;
  logic             at_top;
  logic             at_bottom;
  logic             sat_mode;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

`ifdef COUNTER_MOD_SAT_EN
  assign sat_mode = sat;
`else
  logic unused_sat;
  assign unused_sat = sat;
  assign sat_mode   = 1'b0;
`endif

  assign count_ext = {1'b0, count};
  assign load_ext  = {1'b0, load_val};
  assign at_top    = (count_ext == LAST);
  assign at_bottom = (count_ext == '0);
  assign tc        = en & (up ? at_top : at_bottom);

  // Priority clr > load > en > hold; wrap only pulses after a genuine roll-over.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (clr) begin
      count_next = '0;
    end else if (load) begin
      count_next = (load_ext > LAST) ? LAST[WIDTH-1:0] : load_val;
    end else if (en) begin
      if (up) begin
        if (!at_top) begin
          count_next = count_ext[WIDTH-1:0] + WIDTH'(1);
        end else if (!sat_mode) begin
          count_next = '0;
          wrap_next  = 1'b1;
        end
      end else begin
        if (!at_bottom) begin
          count_next = count_ext[WIDTH-1:0] - WIDTH'(1);
        end else if (!sat_mode) begin
          count_next = LAST[WIDTH-1:0];
          wrap_next  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

endmodule
